// File: rtl/mc_control_unit_if.sv
// mc_control_unit_if: bundle between the multicycle control unit and its datapath/memory side.
// master: control unit (consumes op/mem_ready/stall, drives strobes, controls, state, trap)
// slave : datapath/memory side (drives op/mem_ready/stall, consumes the controls)
interface mc_control_unit_if #(
    parameter int ALU_OP_W = 2
);
    logic [6:0]          op;
    logic                mem_ready;
    logic                stall;
    logic                pc_write;
    logic                ir_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                alu_src;
    logic                reg_write;
    logic                can_branch;
    logic                should_jump;
    logic [ALU_OP_W-1:0] alu_op;
    logic [2:0]          state;
    logic                trap;

    modport master (
        input  op, mem_ready, stall,
        output pc_write, ir_write, mem_read, mem_write, mem_to_reg, alu_src,
               reg_write, can_branch, should_jump, alu_op, state, trap
    );

    modport slave (
        output op, mem_ready, stall,
        input  pc_write, ir_write, mem_read, mem_write, mem_to_reg, alu_src,
               reg_write, can_branch, should_jump, alu_op, state, trap
    );
endinterface

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Ports: clk, rst (sync, active-high), bus (mc_control_unit_if.master).
// Outputs are decoded from state and the latched opcode; FETCH/MEM strobes also use mem_ready.
// Optional macro MC_CU_TIMEOUT_EN: traps when a FETCH/MEM wait reaches MEM_TIMEOUT cycles.
module mc_control_unit #(
    parameter int ALU_OP_W    = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input logic               clk,
    input logic               rst,
    mc_control_unit_if.master bus
);
    if (ALU_OP_W < 2 || ALU_OP_W > 4 || MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_param
        $error("mc_control_unit: illegal parameter value");
    end

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_AI   = 7'b0010011;
    localparam logic [6:0] OP_AR   = 7'b0110011;
    localparam logic [6:0] OP_AUI  = 7'b0010111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5} state_t;

    state_t     st;
    logic [6:0] op_q;
    logic       tmo;
    logic       is_br, is_ld, is_st, is_jp, is_ai, is_ar, is_lu;
    logic       run, go;

    function automatic logic legal_op(input logic [6:0] o);
        return o inside {OP_BR, OP_LD, OP_ST, OP_JALR, OP_JAL, OP_AI, OP_AR, OP_AUI, OP_LUI};
    endfunction

    assign is_br = op_q == OP_BR;
    assign is_ld = op_q == OP_LD;
    assign is_st = op_q == OP_ST;
    assign is_jp = op_q == OP_JAL || op_q == OP_JALR || op_q == OP_AUI;
    assign is_ai = op_q == OP_AI;
    assign is_ar = op_q == OP_AR;
    assign is_lu = op_q == OP_LUI;

`ifdef MC_CU_TIMEOUT_EN
    logic [7:0] wcnt;
    logic       waiting;
    assign waiting = (st == FETCH || st == MEM) && !bus.stall && !bus.mem_ready;
    assign tmo     = waiting && wcnt >= 8'(MEM_TIMEOUT);
    // Stalls freeze the count; any other non-waiting cycle is a phase exit and clears it.
    always_ff @(posedge clk) begin
        if (rst || (!waiting && !bus.stall))
            wcnt <= '0;
        else if (waiting)
            wcnt <= wcnt + 8'd1;
    end
`else
    assign tmo = 1'b0;
`endif

    // Unused encodings 6/7 fall into the default arm and reach TRAP even under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= FETCH;
            op_q <= '0;
        end else if (!bus.stall || st > WB) begin
            case (st)
                FETCH:   st <= bus.mem_ready ? DECODE : tmo ? TRAP : FETCH;
                DECODE: begin
                    op_q <= bus.op;
                    st   <= legal_op(bus.op) ? EXEC : TRAP;
                end
                EXEC:    st <= is_br ? FETCH : (is_ld || is_st) ? MEM : WB;
                MEM:     st <= bus.mem_ready ? (is_ld ? WB : FETCH) : tmo ? TRAP : MEM;
                WB:      st <= FETCH;
                default: st <= TRAP;
            endcase
        end
    end

    assign run = !rst;
    assign go  = !rst && !bus.stall;

    assign bus.mem_read    = run && (st == FETCH || (st == MEM && is_ld));
    assign bus.ir_write    = go && st == FETCH && bus.mem_ready;
    assign bus.pc_write    = go && st == FETCH && bus.mem_ready;
    assign bus.mem_write   = go && st == MEM && is_st;
    assign bus.mem_to_reg  = run && st == WB && is_ld;
    assign bus.reg_write   = go && st == WB;
    assign bus.alu_src     = run && st == EXEC && (is_ld || is_st || is_jp || is_ai || is_lu);
    assign bus.can_branch  = run && st == EXEC && is_br;
    assign bus.should_jump = run && st == EXEC && is_jp;
    assign bus.alu_op      = ALU_OP_W'((run && st == EXEC) ? (is_br ? 2'b01 : is_ar ? 2'b10 : is_ai ? 2'b11 : 2'b00) : 2'b00);
    assign bus.state       = run ? st : 3'd0;
    assign bus.trap        = run && st == TRAP;
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: randomized instruction-level bench for mc_control_unit against a phase-table model.
module tb_mc_control_unit;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_AI   = 7'b0010011;
    localparam logic [6:0] OP_AR   = 7'b0110011;
    localparam logic [6:0] OP_AUI  = 7'b0010111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [6:0] legal_ops [9] = '{OP_BR, OP_LD, OP_ST, OP_JALR, OP_JAL, OP_AI, OP_AR, OP_AUI, OP_LUI};

    mc_control_unit_if #(.ALU_OP_W(2)) bus ();

    mc_control_unit #(.ALU_OP_W(2), .MEM_TIMEOUT(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [6:0] o);
        foreach (legal_ops[i]) if (legal_ops[i] == o) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] outs();
        return {15'd0, bus.state, bus.trap, bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write,
                bus.mem_to_reg, bus.alu_src, bus.reg_write, bus.can_branch, bus.should_jump, 4'(bus.alu_op)};
    endfunction

    // Expected outputs for one cycle, straight from the phase/instruction-class rules.
    function automatic logic [31:0] model(input int ph, input logic [6:0] o, input bit s, input bit r);
        bit ld, sv, br, jp, ai, ar, lu;
        bit tp, pw, iw, mr, mw, m2r, as, rw, cb, sj;
        logic [3:0] ao;
        ld = o == OP_LD; sv = o == OP_ST; br = o == OP_BR; ai = o == OP_AI; ar = o == OP_AR; lu = o == OP_LUI;
        jp = o == OP_JAL || o == OP_JALR || o == OP_AUI;
        {tp, pw, iw, mr, mw, m2r, as, rw, cb, sj} = '0;
        ao = 4'd0;
        case (ph)
            0: begin mr = 1; pw = r && !s; iw = r && !s; end
            2: begin cb = br; sj = jp; as = ld || sv || jp || ai || lu; ao = br ? 4'd1 : ar ? 4'd2 : ai ? 4'd3 : 4'd0; end
            3: begin mr = ld; mw = sv && !s; end
            4: begin rw = !s; m2r = ld; end
            5: tp = 1;
            default: ;
        endcase
        return {15'd0, 3'(ph), tp, pw, iw, mr, mw, m2r, as, rw, cb, sj, ao};
    endfunction

    // One clock: drive inputs on the falling edge, check the settled outputs before the next rise.
    task automatic cyc(input int ph, input logic [6:0] o, input bit s, input bit r, input string tag);
        @(negedge clk);
        rst           = 1'b0;
        bus.stall     = s;
        bus.mem_ready = r;
        bus.op        = ph == 1 ? o : 7'($urandom);
        #1 check(tag, outs(), model(ph, o, s, r));
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            rst           = 1'b1;
            bus.stall     = 1'($urandom);
            bus.mem_ready = 1'($urandom);
            bus.op        = 7'($urandom);
            #1 check("reset_outputs", outs(), 32'd0);
        end
    endtask

    // A phase lasts until one non-stalled cycle completes it; wait phases first need w non-stalled not-ready cycles.
    task automatic phase(input int ph, input logic [6:0] o, input int w, input bit rs, input int fs, input string tag);
        int  n;
        int  f;
        bit  done;
        bit  s;
        bit  r;
        bit  isw;
        n    = w;
        f    = fs;
        done = 0;
        isw  = ph == 0 || ph == 3;
        while (!done) begin
            s = f > 0 ? 1'b1 : rs && ($urandom_range(3) == 0);
            r = (s || !isw) ? 1'($urandom) : (n == 0);
            if (f > 0) f--;
            cyc(ph, o, s, r, tag);
            if (!s) begin
                if (n == 0) done = 1;
                else n--;
            end
        end
    endtask

    task automatic run_instr(input logic [6:0] o, input int fw, input int mw, input bit rs, input int es);
        phase(0, o, fw, rs, 0, "fetch");
        phase(1, o, 0, rs, 0, "decode");
        if (!legal(o)) begin
            repeat (20) cyc(5, o, 1'($urandom), 1'($urandom), "trap_hold");
            do_reset(1);
            return;
        end
        phase(2, o, 0, rs, es, "exec");
        if (o == OP_LD || o == OP_ST) phase(3, o, mw, rs, 0, "mem");
        if (o != OP_BR && o != OP_ST) phase(4, o, 0, rs, 0, "wb");
    endtask

    initial begin
        logic [6:0] o;
        bus.op        = '0;
        bus.stall     = 1'b0;
        bus.mem_ready = 1'b0;
        do_reset(2);
        run_instr(OP_AR, 0, 0, 0, 0);
        run_instr(OP_LD, 0, 3, 0, 0);
        run_instr(7'b0000000, 0, 0, 0, 0);
        run_instr(OP_BR, 0, 0, 0, 2);
        run_instr(OP_ST, 2, 1, 0, 0);
        run_instr(OP_LUI, 0, 0, 0, 0);
        run_instr(OP_JAL, 1, 0, 0, 0);
`ifdef MC_CU_TIMEOUT_EN
        repeat (5) cyc(0, OP_AR, 1'b0, 1'b0, "timeout_fetch");
        cyc(5, OP_AR, 1'b0, 1'b0, "timeout_trap");
        do_reset(1);
        run_instr(OP_AR, 4, 0, 0, 0);
        run_instr(OP_LD, 0, 4, 1, 0);
`endif
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(9) == 0) begin
                do o = 7'($urandom); while (legal(o));
            end else begin
                o = legal_ops[$urandom_range(8)];
            end
            run_instr(o, $urandom_range(3), $urandom_range(3), 1'b1, $urandom_range(1));
            if ($urandom_range(19) == 0) do_reset($urandom_range(1, 2));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameter ALU_OP_W, 2, alu_op width; legal values 2 to 4; bits above [1:0] driven 0.
REQ-002 Parameter MEM_TIMEOUT, 15, max wait cycles on mem_ready per memory phase; legal values 1 to 255.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 op  in  7  opcode of fetched instruction; sampled only in DECODE.
REQ-006 mem_ready  in  1  memory handshake; completes current fetch or data access.
REQ-007 stall  in  1  freeze request from hazard logic.
REQ-008 pc_write, ir_write  out  1 each  PC and IR update strobes.
REQ-009 mem_read, mem_write, mem_to_reg, alu_src, reg_write, can_branch, should_jump  out  1 each  datapath controls.
REQ-010 alu_op  out  ALU_OP_W  ALU class: 00 add, 01 branch compare, 10 R-type, 11 I-type.
REQ-011 state  out  3  current state encoding, for debug.
REQ-012 trap  out  1  sticky fault flag.

Function
REQ-013 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 SHALL go to TRAP next cycle.
REQ-014 Opcodes SHALL be standard RV32I: Branch, Load, Store, JALR, JAL, Arith_I, Arith_R, AUIPC, LUI; all others illegal.
REQ-015 FETCH: mem_read=1; on mem_ready, ir_write=1 and pc_write=1 in that cycle, next DECODE; otherwise hold.
REQ-016 DECODE: op registered into op_q; illegal op -> TRAP, else -> EXEC.
REQ-017 EXEC: Branch -> can_branch=1, alu_op=01, next FETCH; Load/Store -> alu_src=1, alu_op=00, next MEM; JAL/JALR/AUIPC -> should_jump=1, alu_src=1; Arith_I -> alu_src=1, alu_op=11; Arith_R -> alu_op=10; LUI -> alu_src=1; all non-memory, non-branch classes next WB.
REQ-018 MEM: Load drives mem_read=1, Store drives mem_write=1, held until mem_ready; then Load -> WB, Store -> FETCH.
REQ-019 WB: reg_write=1 for one cycle; mem_to_reg=1 only for Load; next FETCH.
REQ-020 Zero-wait latency: Branch 3 cycles, Store 4, ALU/jump/LUI/AUIPC 4, Load 5, FETCH entry to next FETCH entry.
REQ-021 Outputs SHALL be combinational from state and op_q only (Moore, except FETCH/MEM strobes gated by mem_ready as stated); unlisted outputs 0.
REQ-022 stall=1 in any non-TRAP state: state, op_q and wait counter hold; pc_write, ir_write, reg_write, mem_write forced 0; mem_ready ignored.
REQ-023 TRAP: all outputs 0 except trap=1; exit only by rst.

Reset
REQ-024 rst=1 at a rising edge SHALL set state=FETCH, op_q=0, wait counter=0, trap=0, regardless of current state or pending access.
REQ-025 While rst=1 all outputs SHALL be 0; first cycle after release SHALL present FETCH with mem_read=1.

Configuration
REQ-026 Macro MC_CU_TIMEOUT_EN defined: 8-bit wait counter increments each non-stalled FETCH/MEM cycle with mem_ready=0, clears on phase exit; count reaching MEM_TIMEOUT with mem_ready=0 -> TRAP next cycle; mem_ready in same cycle wins.
REQ-027 Macro undefined: no counter logic; FETCH/MEM wait indefinitely; TRAP reachable only via illegal op or illegal state.

Verification
REQ-028 rst 2 cycles, release, mem_ready=1 constant, op=Arith_R (0110011) -> states 0,1,2,4,0; reg_write=1 only in WB; alu_op=10 in EXEC.
REQ-029 op=Load (0000011), mem_ready low 3 cycles in MEM -> mem_read held 4 cycles, then WB with mem_to_reg=1, reg_write=1.
REQ-030 op=0000000 -> DECODE then TRAP; trap=1 held 20 cycles; rst -> state=0, trap=0.
REQ-031 stall=1 for 2 cycles in EXEC of Branch (1100011) -> state holds 2, can_branch=1 throughout, then FETCH.
REQ-032 MC_CU_TIMEOUT_EN defined, MEM_TIMEOUT=4, mem_ready=0 in FETCH -> TRAP after 5 FETCH cycles; repeat with mem_ready=1 on count 4 -> DECODE, no trap.
